// File: rtl/fun_sched.sv
// Job scheduler around one multi-cycle fun unit (a * floor(cbrt(b))):
// FIFO-queued tagged jobs, one in flight, results through a valid/ready register.
module fun #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy,
    output logic [RES_W-1:0]  result
);
    logic       rst_sub;
    logic       vld_p0;
    logic       vld_p1;
    logic [2:0] root_p0;
    logic       root_done;

    function automatic logic [9:0] cube(input logic [2:0] r);
        return {7'd0, r} * {7'd0, r} * {7'd0, r};
    endfunction

    assign root_done = (10'(b_i) < cube(root_p0 + 3'd1));
    assign busy      = vld_p0 | vld_p1;

    // The datapath leaves reset one cycle after rst deasserts.
    always_ff @(posedge clk) rst_sub <= rst;

    // stage p0: iterative cube-root search over b_i; p1: product ready
    always_ff @(posedge clk) begin
        if (rst || rst_sub) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (start && !busy)
                vld_p0 <= 1'b1;
            else if (vld_p0 && root_done)
                vld_p0 <= 1'b0;
            vld_p1 <= vld_p0 && root_done;
        end
    end

    always_ff @(posedge clk) begin
        if (start && !busy)
            root_p0 <= 3'd0;
        else if (vld_p0 && !root_done)
            root_p0 <= root_p0 + 3'd1;
        if (vld_p0 && root_done)
            result <= RES_W'(a_i) * RES_W'(root_p0);
    end
endmodule

module fun_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_a,
    input  logic [7:0]                 in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [10:0]                out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 jobs_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic [7:0]       mem_a   [DEPTH];
    logic [7:0]       mem_b   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             push, pop, empty;
    logic             ready_q, init_cnt, busy_seen;
    logic [7:0]       job_a, job_b;
    logic [TAG_W-1:0] job_tag;
    logic             start, fun_busy, load_out;
    logic [10:0]      fun_result;

    assign empty     = (count == '0);
    assign push      = in_valid && ready_q;
    assign in_ready  = ready_q;
    assign pop       = (state == IDLE) && !empty;
    assign start     = (state == ISSUE);
    assign load_out  = (state == DONE) && (!out_valid || out_ready);
    assign count_nxt = count + CW'(push) - CW'(pop);

    fun #(.DATA_W(8), .RES_W(11)) u_fun (
        .clk    (clk),
        .rst    (~rst_n),
        .start  (start),
        .a_i    (job_a),
        .b_i    (job_b),
        .busy   (fun_busy),
        .result (fun_result)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            INIT:    if (init_cnt) state_nxt = IDLE;
            IDLE:    if (!empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (busy_seen && !fun_busy) state_nxt = DONE;
            DONE:    if (!out_valid || out_ready) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // in_ready is registered from the next count so it never sees out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            init_cnt   <= 1'b0;
            busy_seen  <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ready_q    <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            jobs_done  <= '0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            ready_q <= (count_nxt != CW'(DEPTH));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (state == INIT) init_cnt <= 1'b1;
            if (state == ISSUE)
                busy_seen <= 1'b0;
            else if (state == WAIT && fun_busy)
                busy_seen <= 1'b1;
            if (load_out) begin
                out_valid  <= 1'b1;
                out_result <= fun_result;
                out_tag    <= job_tag;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready) jobs_done <= jobs_done + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_tag[wr_ptr] <= in_tag;
        end
        if (pop) begin
            job_a   <= mem_a[rd_ptr];
            job_b   <= mem_b[rd_ptr];
            job_tag <= mem_tag[rd_ptr];
        end
    end
endmodule
